// File: rtl/motor_duty_ramp.sv
// rtl/motor_duty_ramp.sv - soft-start / slew controller feeding the PWM duty input
//
// Purpose:
//   Moves the PWM duty magnitude toward a signed speed command at a fixed
//   rate of STEP counts every PRESCALE clocks. A change of direction first
//   ramps the duty to zero, then holds zero for DEAD_TICKS ramp ticks before
//   the H-bridge direction bit flips. Also provides a soft stop (enable low)
//   and an immediate brake.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   target       in   signed two's-complement speed command (LENGTH+1 bits)
//   target_valid in   one-cycle strobe, captures target
//   enable       in   0 = soft stop (ramp to 0), captured target retained
//   brake        in   1 = duty forced to 0 on the next edge, held while high
//   duty         out  duty magnitude to the PWM stage (registered)
//   dir          out  0 = forward, 1 = reverse (registered)
//   at_target    out  duty/dir match the effective target and not in DEAD
//   state        out  00 IDLE, 01 RAMP, 10 DEAD
module motor_duty_ramp #(
  parameter int LENGTH     = 10,
  parameter int PRESCALE   = 1000,
  parameter int STEP       = 4,
  parameter int DEAD_TICKS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LENGTH:0]   target,
  input  logic              target_valid,
  input  logic              enable,
  input  logic              brake,
  output logic [LENGTH-1:0] duty,
  output logic              dir,
  output logic              at_target,
  output logic [1:0]        state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(DEAD_TICKS + 1);

  localparam logic [PW-1:0]   PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [DW-1:0]   DEAD_LOAD = DW'(DEAD_TICKS);
  localparam logic [DW-1:0]   DEAD_ONE  = DW'(1);
  localparam logic [LENGTH:0] STEP_X    = (LENGTH + 1)'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RAMP = 2'b01,
    S_DEAD = 2'b10
  } state_t;

  // ------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------
  logic [PW-1:0]     r_pre;
  logic [LENGTH-1:0] r_tgt_mag;
  logic              r_tgt_dir;
  logic [LENGTH-1:0] r_duty;
  logic              r_dir;
  state_t            r_state;
  logic [DW-1:0]     r_dead;

  // ------------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------------
  logic              w_tick;
  logic [LENGTH:0]   w_neg;
  logic [LENGTH:0]   w_abs;
  logic [LENGTH-1:0] w_cap_mag;
  logic [LENGTH-1:0] w_eff_mag;
  logic              w_reversal;
  logic [LENGTH:0]   w_duty_x;
  logic [LENGTH:0]   w_eff_x;
  logic [LENGTH-1:0] w_step_to_zero;
  logic [LENGTH-1:0] w_step_up;
  logic [LENGTH-1:0] w_step_down;

  // Free-running tick; commands never restart it, so slew timing stays fixed.
  assign w_tick = (r_pre == PRE_LAST);

  // Magnitude of the command. The most negative code has no positive
  // counterpart in LENGTH bits, so it saturates to full scale.
  assign w_neg     = ~target + 1'b1;
  assign w_abs     = target[LENGTH] ? w_neg : target;
  assign w_cap_mag = w_abs[LENGTH] ? {LENGTH{1'b1}} : w_abs[LENGTH-1:0];

  assign w_eff_mag  = (enable && !brake) ? r_tgt_mag : '0;
  assign w_reversal = (w_eff_mag != '0) && (r_tgt_dir != r_dir);

  // One extra bit of headroom so that neither add nor subtract can wrap.
  assign w_duty_x = {1'b0, r_duty};
  assign w_eff_x  = {1'b0, w_eff_mag};

  assign w_step_to_zero = (w_duty_x <= STEP_X) ? '0
                                               : LENGTH'(w_duty_x - STEP_X);

  // Final step lands exactly on the goal instead of overshooting it.
  assign w_step_up   = ((w_eff_x - w_duty_x) <= STEP_X) ? w_eff_mag
                                                        : LENGTH'(w_duty_x + STEP_X);
  assign w_step_down = ((w_duty_x - w_eff_x) <= STEP_X) ? w_eff_mag
                                                        : LENGTH'(w_duty_x - STEP_X);

  // ------------------------------------------------------------------------
  // Ramp tick prescaler
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Command capture. A zero command carries no direction, so the previous
  // direction is kept and a stop never causes a reversal.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt_mag <= '0;
      r_tgt_dir <= 1'b0;
    end else if (target_valid) begin
      r_tgt_mag <= w_cap_mag;
      if (target != '0) begin
        r_tgt_dir <= target[LENGTH];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Ramp state machine: owns duty, dir and the dead-time counter.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty  <= '0;
      r_dir   <= 1'b0;
      r_state <= S_IDLE;
      r_dead  <= '0;
    end else if (brake) begin
      // Dead counter and dir are left alone; a pending reversal is
      // re-evaluated from IDLE once the brake is released.
      r_duty  <= '0;
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_reversal) begin
            r_state <= S_DEAD;
            r_dead  <= DEAD_LOAD;
          end else if (w_eff_mag != '0) begin
            r_state <= S_RAMP;
          end
        end

        S_RAMP: begin
          if (w_tick) begin
            if (w_reversal) begin
              r_duty <= w_step_to_zero;
              if (w_step_to_zero == '0) begin
                r_state <= S_DEAD;
                r_dead  <= DEAD_LOAD;
              end
            end else if (r_duty < w_eff_mag) begin
              r_duty <= w_step_up;
            end else if (r_duty > w_eff_mag) begin
              r_duty <= w_step_down;
            end else if (r_duty == '0) begin
              r_state <= S_IDLE;
            end
          end
        end

        S_DEAD: begin
          if (w_tick) begin
            if (r_dead <= DEAD_ONE) begin
              r_dead  <= '0;
              r_state <= S_IDLE;
              // A reversal withdrawn during dead time leaves dir as it was.
              if (w_reversal) begin
                r_dir <= r_tgt_dir;
              end
            end else begin
              r_dead <= r_dead - DEAD_ONE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign duty      = r_duty;
  assign dir       = r_dir;
  assign state     = r_state;
  assign at_target = (r_state != S_DEAD) &&
                     (r_duty == w_eff_mag) &&
                     ((w_eff_mag == '0) || (r_dir == r_tgt_dir));

endmodule

// File: tb/tb_motor_duty_ramp.sv
// tb/tb_motor_duty_ramp.sv - directed self-checking bench for motor_duty_ramp
module tb_motor_duty_ramp;

  logic        clk;
  logic        rst_n;
  logic [10:0] target;
  logic        target_valid;
  logic        enable;
  logic        brake;
  logic [9:0]  duty;
  logic        dir;
  logic        at_target;
  logic [1:0]  state;

  int n_cmp;
  int n_fail;
  int k;

  motor_duty_ramp #(
    .LENGTH    (10),
    .PRESCALE  (4),
    .STEP      (4),
    .DEAD_TICKS(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .target      (target),
    .target_valid(target_valid),
    .enable      (enable),
    .brake       (brake),
    .duty        (duty),
    .dir         (dir),
    .at_target   (at_target),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; with PRESCALE=4 every edge where k%4==0 is a tick edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      step_clk();
      if (k % 4 == 0) c++;
    end
  endtask

  task automatic align();
    step_clk();
    while (k % 4 != 0) step_clk();
  endtask

  task automatic strobe(input logic [10:0] v);
    target       = v;
    target_valid = 1'b1;
    step_clk();
    target_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step_clk();
    step_clk();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    step_clk();
    n_cmp++; if (duty !== 10'd0) begin n_fail++; $display("FAIL reset_duty: got %0d want 0", duty); end
    n_cmp++; if (dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %0b want 0", dir); end
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
    n_cmp++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL reset_at_target: got %0b want 1", at_target); end
    rst_n = 1'b1;
    ticks(2);
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_idle_hold: got %b want 00", state); end
  endtask

  task automatic test_ramp_up();
    apply_reset();
    align();
    strobe(11'd100);
    ticks(1);
    n_cmp++; if (duty !== 10'd4) begin n_fail++; $display("FAIL up_first_tick: got %0d want 4", duty); end
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL up_state: got %b want 01", state); end
    ticks(23);
    n_cmp++; if (duty !== 10'd96) begin n_fail++; $display("FAIL up_tick24: got %0d want 96", duty); end
    n_cmp++; if (at_target !== 1'b0) begin n_fail++; $display("FAIL up_at_target24: got %0b want 0", at_target); end
    ticks(1);
    n_cmp++; if (duty !== 10'd100) begin n_fail++; $display("FAIL up_tick25: got %0d want 100", duty); end
    n_cmp++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL up_at_target25: got %0b want 1", at_target); end
    n_cmp++; if (dir !== 1'b0) begin n_fail++; $display("FAIL up_dir: got %0b want 0", dir); end
  endtask

  task automatic test_no_overshoot();
    apply_reset();
    align();
    strobe(11'd102);
    ticks(25);
    n_cmp++; if (duty !== 10'd100) begin n_fail++; $display("FAIL ovs_tick25: got %0d want 100", duty); end
    ticks(1);
    n_cmp++; if (duty !== 10'd102) begin n_fail++; $display("FAIL ovs_tick26: got %0d want 102", duty); end
    n_cmp++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL ovs_at_target: got %0b want 1", at_target); end
    ticks(1);
    n_cmp++; if (duty !== 10'd102) begin n_fail++; $display("FAIL ovs_hold: got %0d want 102", duty); end
    // Capture coincident with a tick: that tick still uses the old target.
    step_clk();
    step_clk();
    step_clk();
    target       = 11'd110;
    target_valid = 1'b1;
    step_clk();
    target_valid = 1'b0;
    n_cmp++; if (duty !== 10'd102) begin n_fail++; $display("FAIL tickcap_same: got %0d want 102", duty); end
    ticks(1);
    n_cmp++; if (duty !== 10'd106) begin n_fail++; $display("FAIL tickcap_next: got %0d want 106", duty); end
    strobe(11'd100);
    ticks(1);
    n_cmp++; if (duty !== 10'd102) begin n_fail++; $display("FAIL down_partial: got %0d want 102", duty); end
    ticks(1);
    n_cmp++; if (duty !== 10'd100) begin n_fail++; $display("FAIL down_exact: got %0d want 100", duty); end
  endtask

  task automatic test_reversal();
    strobe(-11'sd40);
    ticks(24);
    n_cmp++; if (duty !== 10'd4) begin n_fail++; $display("FAIL rev_tick24: got %0d want 4", duty); end
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL rev_state24: got %b want 01", state); end
    ticks(1);
    n_cmp++; if (duty !== 10'd0) begin n_fail++; $display("FAIL rev_zero: got %0d want 0", duty); end
    n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL rev_dead: got %b want 10", state); end
    n_cmp++; if (dir !== 1'b0) begin n_fail++; $display("FAIL rev_dir_dead: got %0b want 0", dir); end
    n_cmp++; if (at_target !== 1'b0) begin n_fail++; $display("FAIL rev_at_target_dead: got %0b want 0", at_target); end
    ticks(1);
    n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL rev_dead2: got %b want 10", state); end
    ticks(1);
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL rev_idle: got %b want 00", state); end
    n_cmp++; if (dir !== 1'b1) begin n_fail++; $display("FAIL rev_dir_flip: got %0b want 1", dir); end
    step_clk();
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL rev_ramp: got %b want 01", state); end
    ticks(10);
    n_cmp++; if (duty !== 10'd40) begin n_fail++; $display("FAIL rev_duty40: got %0d want 40", duty); end
    n_cmp++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL rev_at_target40: got %0b want 1", at_target); end
  endtask

  task automatic test_brake();
    align();
    strobe(-11'sd60);
    ticks(5);
    n_cmp++; if (duty !== 10'd60) begin n_fail++; $display("FAIL brk_pre: got %0d want 60", duty); end
    align();
    brake = 1'b1;
    step_clk();
    n_cmp++; if (duty !== 10'd0) begin n_fail++; $display("FAIL brk_duty: got %0d want 0", duty); end
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL brk_state: got %b want 00", state); end
    repeat (9) step_clk();
    n_cmp++; if (duty !== 10'd0) begin n_fail++; $display("FAIL brk_held: got %0d want 0", duty); end
    n_cmp++; if (dir !== 1'b1) begin n_fail++; $display("FAIL brk_dir: got %0b want 1", dir); end
    brake = 1'b0;
    ticks(14);
    n_cmp++; if (duty !== 10'd56) begin n_fail++; $display("FAIL brk_tick14: got %0d want 56", duty); end
    ticks(1);
    n_cmp++; if (duty !== 10'd60) begin n_fail++; $display("FAIL brk_tick15: got %0d want 60", duty); end
    n_cmp++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL brk_at_target: got %0b want 1", at_target); end
  endtask

  task automatic test_soft_stop();
    align();
    strobe(-11'sd80);
    ticks(5);
    n_cmp++; if (duty !== 10'd80) begin n_fail++; $display("FAIL ss_pre: got %0d want 80", duty); end
    align();
    enable = 1'b0;
    ticks(19);
    n_cmp++; if (duty !== 10'd4) begin n_fail++; $display("FAIL ss_tick19: got %0d want 4", duty); end
    ticks(1);
    n_cmp++; if (duty !== 10'd0) begin n_fail++; $display("FAIL ss_tick20: got %0d want 0", duty); end
    n_cmp++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL ss_at_target: got %0b want 1", at_target); end
    n_cmp++; if (dir !== 1'b1) begin n_fail++; $display("FAIL ss_dir: got %0b want 1", dir); end
    ticks(1);
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL ss_idle: got %b want 00", state); end
    enable = 1'b1;
    ticks(20);
    n_cmp++; if (duty !== 10'd80) begin n_fail++; $display("FAIL ss_back: got %0d want 80", duty); end
    n_cmp++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL ss_back_at_target: got %0b want 1", at_target); end
  endtask

  task automatic test_saturate_and_async_reset();
    apply_reset();
    align();
    strobe(11'b100_0000_0000);
    step_clk();
    n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL sat_dead: got %b want 10", state); end
    ticks(1);
    n_cmp++; if (dir !== 1'b0) begin n_fail++; $display("FAIL sat_dir_dead: got %0b want 0", dir); end
    ticks(1);
    n_cmp++; if (dir !== 1'b1) begin n_fail++; $display("FAIL sat_dir_flip: got %0b want 1", dir); end
    ticks(255);
    n_cmp++; if (duty !== 10'd1020) begin n_fail++; $display("FAIL sat_tick255: got %0d want 1020", duty); end
    ticks(1);
    n_cmp++; if (duty !== 10'd1023) begin n_fail++; $display("FAIL sat_full: got %0d want 1023", duty); end
    n_cmp++; if (at_target !== 1'b1) begin n_fail++; $display("FAIL sat_at_target: got %0b want 1", at_target); end
    strobe(11'd0);
    ticks(2);
    n_cmp++; if (duty !== 10'd1015) begin n_fail++; $display("FAIL zero_cmd_ramp: got %0d want 1015", duty); end
    n_cmp++; if (dir !== 1'b1) begin n_fail++; $display("FAIL zero_cmd_dir: got %0b want 1", dir); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (duty !== 10'd0) begin n_fail++; $display("FAIL async_duty: got %0d want 0", duty); end
    n_cmp++; if (dir !== 1'b0) begin n_fail++; $display("FAIL async_dir: got %0b want 0", dir); end
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL async_state: got %b want 00", state); end
    step_clk();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    target       = '0;
    target_valid = 1'b0;
    enable       = 1'b1;
    brake        = 1'b0;
    test_reset();
    test_ramp_up();
    test_no_overshoot();
    test_reversal();
    test_brake();
    test_soft_stop();
    test_saturate_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_duty_ramp.md
Name: motor_duty_ramp

Overview:
Soft-start/slew controller that sits directly upstream of the PWM generator. It drives that generator's duty input and supplies the H-bridge direction bit. It takes a signed speed command and slews the duty magnitude toward it at a fixed rate. On a direction reversal it ramps down to zero, inserts a dead time, then flips direction. It also provides a soft stop (enable low) and an immediate brake.

Parameters:
LENGTH, 10, duty width in bits; must match the downstream PWM width
PRESCALE, 1000, clock cycles per ramp tick (>=1)
STEP, 4, duty change per tick (1..2^LENGTH-1)
DEAD_TICKS, 8, ticks at duty 0 before a direction flip (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
target  in  LENGTH+1  signed two's-complement speed command
target_valid  in  1  one-cycle strobe; captures target
enable  in  1  0 = soft stop (ramp to 0), target register retained
brake  in  1  1 = duty forced to 0 next edge, held while high
duty  out  LENGTH  duty magnitude to the PWM stage (registered)
dir  out  1  0 = forward, 1 = reverse (registered)
at_target  out  1  duty/dir equal effective target, not in DEAD
state  out  2  00 IDLE, 01 RAMP, 10 DEAD (debug)

Behaviour:
- Reset (async): duty=0, dir=0, target register mag=0 and sign=0, state=IDLE, prescaler=0, dead counter=0. Reset applied mid-ramp clears everything immediately.
- Capture: on target_valid, tgt_mag=|target| and tgt_dir=sign.
  - |-2^LENGTH| saturates to 2^LENGTH-1.
  - target=0 gives tgt_mag=0, and tgt_dir is left unchanged.
- Effective magnitude: eff_mag = (enable && !brake) ? tgt_mag : 0. A change is a reversal when eff_mag!=0 and tgt_dir!=dir.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 in the cycle the count equals PRESCALE-1. It free-runs from reset and is never restarted by commands.
- A target captured in the same cycle as a tick takes effect from the next tick.
- IDLE (duty==0):
  - No reversal and eff_mag>0: go to RAMP.
  - Reversal: go to DEAD and load the dead counter with DEAD_TICKS.
- RAMP, acting on tick only:
  - Reversal: duty = (duty<=STEP) ? 0 : duty-STEP. When the result is 0, go to DEAD and load the dead counter.
  - duty<eff_mag: duty = (eff_mag-duty<=STEP) ? eff_mag : duty+STEP. No overshoot.
  - duty>eff_mag: duty = (duty-eff_mag<=STEP) ? eff_mag : duty-STEP.
  - duty==eff_mag==0: go to IDLE.
  - All arithmetic is done in LENGTH+1 bits, so there is no wrap.
- DEAD: duty held at 0 and dir unchanged.
  - Each tick decrements the counter.
  - When the counter reaches 0: dir=tgt_dir and go to IDLE. The next cycle proceeds to RAMP.
  - If the reversal is withdrawn during DEAD (new target with the old sign, or eff_mag=0), dir is not flipped. The counter still completes before leaving DEAD.
- Brake: overrides everything. Next edge duty=0 and state=IDLE; dir and the dead counter are unchanged. target_valid in the same cycle is still captured. After release, the block ramps from 0 per the normal rules.
- at_target: combinational decode of registers. It is 1 when state!=DEAD, duty==eff_mag, and (eff_mag==0 or dir==tgt_dir).
- duty changes only on tick edges, except for brake and reset.

Test Plan:
All scenarios use LENGTH=10, PRESCALE=4, STEP=4, DEAD_TICKS=2.
1. Reset, then target=+100 strobe: duty rises by 4 every 4 clks and reaches 100 after 25 ticks. at_target=1 from that edge; dir stays 0.
2. From 0, target=+102: duty=100 after 25 ticks, then exactly 102 on tick 26. No overshoot; holds at 102.
3. At +100, target=-40: duty ramps to 0 in 25 ticks with dir=0. DEAD holds duty=0 for 2 ticks, then dir=1. duty reaches 40 after 10 further ticks.
4. At duty=60, brake=1 for 10 clks: duty=0 on the next edge and state=IDLE. After release, duty ramps 0→60 in 15 ticks with target unchanged.
5. At duty=80, enable=0: duty falls to 0 in 20 ticks, dir held, at_target=1 at 0. enable=1: duty returns to 80 in 20 ticks.
6. target=-1024 gives tgt_mag=1023 and dir=1 after DEAD. Asserting rst_n=0 mid-ramp makes duty=0, dir=0, state=IDLE asynchronously, with no clock edge needed.
